// File: rtl/snake_dir_key_filter.sv
// Direction-key front end for the snake game: per-key sync, debounce and press
// pulse, plus the prioritised, reversal-rejecting heading register.
module snake_dir_key_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter logic [1:0]  INIT_DIR        = 2'b01
) (
  input  logic       Clk_50mhz,
  input  logic       Rst,
  input  logic       Left,
  input  logic       Right,
  input  logic       Up,
  input  logic       Down,
  input  logic [2:0] Game_status,
  output logic       Key_left,
  output logic       Key_right,
  output logic       Key_up,
  output logic       Key_down,
  output logic       Key_any,
  output logic [1:0] Dir,
  output logic       Dir_change
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam dir_t             DIR_INIT = dir_t'(INIT_DIR);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Key lanes: 0 up, 1 down, 2 left, 3 right (also the heading priority order).
  logic [3:0]       raw_vec;
  logic [3:0]       pressed;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       stable_d;
  logic [3:0]       pulse;
  logic             any_q;
  logic [CNT_W-1:0] cnt [4];

  dir_t       dir;
  dir_t       cand;
  logic [1:0] rev;
  logic       dir_change_q;

  assign raw_vec = {Right, Left, Down, Up};
  assign pressed = KEY_ACTIVE_LOW ? ~raw_vec : raw_vec;

  always_ff @(posedge Clk_50mhz) begin
    if (Rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      pulse    <= '0;
      any_q    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= pressed;
      sync2    <= sync1;
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      any_q    <= |(stable & ~stable_d);
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= ~stable[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Only the highest-priority pulse is considered; the rest are dropped.
  always_comb begin
    cand = dir;
    if (pulse[0])      cand = DIR_UP;
    else if (pulse[1]) cand = DIR_DOWN;
    else if (pulse[2]) cand = DIR_LEFT;
    else if (pulse[3]) cand = DIR_RIGHT;
  end

  assign rev = dir ^ 2'b10;

  always_ff @(posedge Clk_50mhz) begin
    if (Rst) begin
      dir          <= DIR_INIT;
      dir_change_q <= 1'b0;
    end else begin
      dir_change_q <= 1'b0;
      case (Game_status)
        3'b001: begin
          if (dir != DIR_INIT) begin
            dir          <= DIR_INIT;
            dir_change_q <= 1'b1;
          end
        end
        3'b010: begin
          if (|pulse && cand != dir && cand != rev) begin
            dir          <= cand;
            dir_change_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Key_up     = pulse[0];
  assign Key_down   = pulse[1];
  assign Key_left   = pulse[2];
  assign Key_right  = pulse[3];
  assign Key_any    = any_q;
  assign Dir        = dir;
  assign Dir_change = dir_change_q;

endmodule

// File: tb/tb_snake_dir_key_filter.sv
// Randomised and directed bench for snake_dir_key_filter against a
// sample-window reference model of sync, debounce, pulse and heading rules.
module tb_snake_dir_key_filter;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;     // 0 up, 1 down, 2 left, 3 right; active low
  logic [2:0] status;

  logic key_left, key_right, key_up, key_down, key_any, dir_change;
  logic [1:0] dir;

  int n_vec = 0;
  int n_err = 0;

  snake_dir_key_filter #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3),
    .KEY_ACTIVE_LOW(1'b1),
    .INIT_DIR(2'b01)
  ) dut (
    .Clk_50mhz(clk),
    .Rst(rst),
    .Left(raw[2]),
    .Right(raw[3]),
    .Up(raw[0]),
    .Down(raw[1]),
    .Game_status(status),
    .Key_left(key_left),
    .Key_right(key_right),
    .Key_up(key_up),
    .Key_down(key_down),
    .Key_any(key_any),
    .Dir(dir),
    .Dir_change(dir_change)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit         m_s1 [4];
  bit         m_s2 [4];
  bit         m_stable [4];
  bit         m_rose [4];
  bit         m_pulse [4];
  bit         m_win [4][D];
  bit         m_any;
  logic [1:0] m_dir;
  bit         m_dchg;
  logic [1:0] code [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    bit found;
    bit all_diff;
    logic [1:0] c;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_stable[k] = 0; m_rose[k] = 0; m_pulse[k] = 0;
        for (int j = 0; j < D; j++) m_win[k][j] = 0;
      end
      m_any = 0; m_dir = 2'b01; m_dchg = 0;
    end else begin
      m_dchg = 0;
      if (status == 3'b001) begin
        if (m_dir != 2'b01) begin m_dir = 2'b01; m_dchg = 1; end
      end else if (status == 3'b010) begin
        found = 0; c = 2'b00;
        for (int k = 0; k < 4; k++)
          if (!found && m_pulse[k]) begin found = 1; c = code[k]; end
        if (found && c != m_dir && c != (m_dir ^ 2'b10)) begin m_dir = c; m_dchg = 1; end
      end
      m_any = 0;
      for (int k = 0; k < 4; k++) begin
        m_pulse[k] = m_rose[k];
        m_any |= m_rose[k];
      end
      for (int k = 0; k < 4; k++) begin
        // Level flips once the last D synchronised samples all disagree with it.
        for (int j = D - 1; j > 0; j--) m_win[k][j] = m_win[k][j-1];
        m_win[k][0] = m_s2[k];
        all_diff = 1;
        for (int j = 0; j < D; j++) if (m_win[k][j] == m_stable[k]) all_diff = 0;
        m_rose[k] = 0;
        if (all_diff) begin
          m_stable[k] = !m_stable[k];
          m_rose[k] = m_stable[k];
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = !raw[k];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("key_up",     key_up,     m_pulse[0]);
    chk("key_down",   key_down,   m_pulse[1]);
    chk("key_left",   key_left,   m_pulse[2]);
    chk("key_right",  key_right,  m_pulse[3]);
    chk("key_any",    key_any,    m_any);
    chk("dir",        dir,        m_dir);
    chk("dir_change", dir_change, m_dchg);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int n_left;
  int sel;

  initial begin
    rst = 1'b1; raw = 4'hF; status = 3'b001;
    run(3);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      chk("t1_dir", dir, 2'b01);
      chk("t1_any", key_any, 1'b0);
      chk("t1_dchg", dir_change, 1'b0);
    end

    status = 3'b010;
    run(2);

    // Left is a reversal of the initial right heading
    raw[2] = 1'b0;
    n_left = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_left += int'(key_left);
      chk("t3_dir", dir, 2'b01);
      chk("t3_dchg", dir_change, 1'b0);
    end
    chk("t3_npulse", n_left, 1);
    raw[2] = 1'b1;
    run(10);

    raw[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t2_early", key_up, 1'b0);
    end
    step();
    chk("t2_up", key_up, 1'b1);
    chk("t2_dir_before", dir, 2'b01);
    step();
    chk("t2_dir", dir, 2'b00);
    chk("t2_dchg", dir_change, 1'b1);
    chk("t2_up_once", key_up, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_hold", key_up, 1'b0);
      chk("t2_hold_dchg", dir_change, 1'b0);
    end
    raw[0] = 1'b1;
    run(10);

    status = 3'b001;
    step();
    chk("start_dir", dir, 2'b01);
    chk("start_dchg", dir_change, 1'b1);
    step();
    chk("start_dchg_off", dir_change, 1'b0);
    status = 3'b010;
    step();

    raw[0] = 1'b0; raw[1] = 1'b0;
    run(6);
    step();
    chk("t4_up", key_up, 1'b1);
    chk("t4_down", key_down, 1'b1);
    chk("t4_any", key_any, 1'b1);
    step();
    chk("t4_dir", dir, 2'b00);
    chk("t4_dchg", dir_change, 1'b1);
    step();
    chk("t4_dchg_once", dir_change, 1'b0);
    raw[0] = 1'b1; raw[1] = 1'b1;
    run(10);

    raw[1] = 1'b0;
    run(3);
    raw[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_glitch", key_down, 1'b0);
      chk("t5_dir", dir, 2'b00);
    end

    // Reset while the down counter is part-way through
    raw[1] = 1'b0;
    run(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_rst_early", key_down, 1'b0);
    end
    step();
    chk("t5_rst_pulse", key_down, 1'b1);
    step();
    chk("t5_rst_dir", dir, 2'b10);
    raw[1] = 1'b1;
    run(10);

    status = 3'b100;
    raw[3] = 1'b0;
    run(6);
    step();
    chk("t6_right", key_right, 1'b1);
    step();
    chk("t6_dir", dir, 2'b10);
    chk("t6_dchg", dir_change, 1'b0);
    raw[3] = 1'b1;
    run(10);
    status = 3'b001;
    step();
    chk("t6_start_dir", dir, 2'b01);
    chk("t6_start_dchg", dir_change, 1'b1);
    step();
    chk("t6_start_once", dir_change, 1'b0);

    for (int s = 0; s < 300; s++) begin
      raw = 4'hF;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 3) == 0) raw[k] = 1'b0;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: status = 3'b001;
        1: status = 3'b100;
        2: status = 3'(($urandom_range(0, 1) == 0) ? 3'b000 : 3'b011);
        default: status = 3'b010;
      endcase
      rst = ($urandom_range(0, 49) == 0);
      step();
      rst = 1'b0;
      run(int'($urandom_range(0, 9)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
